// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one single-port pmem between the IFU (port 0) and LSU (port 1).
// One access in flight at a time: accept, issue one mem_en_o pulse, wait the read latency, respond.
module pmem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_req_valid_i,
  output logic                    ifu_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr_i,
  output logic                    ifu_resp_valid_o,
  input  logic                    ifu_resp_ready_i,
  output logic [DATA_WIDTH-1:0]   ifu_rdata_o,
  input  logic                    lsu_req_valid_i,
  output logic                    lsu_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
  input  logic                    lsu_we_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] lsu_wmask_i,
  output logic                    lsu_resp_valid_o,
  input  logic                    lsu_resp_ready_i,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int MW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;   // 0 = IFU, 1 = LSU
  logic                  last_q, last_d;     // requester granted most recently
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MW-1:0]         wmask_q, wmask_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] ifu_rdata_q, ifu_rdata_d;
  logic [DATA_WIDTH-1:0] lsu_rdata_q, lsu_rdata_d;

  logic grant_ifu, grant_lsu, resp_ready;

  // On a tie the requester that did not win last time gets the grant.
  assign grant_ifu  = ifu_req_valid_i && (!lsu_req_valid_i || last_q);
  assign grant_lsu  = lsu_req_valid_i && (!ifu_req_valid_i || !last_q);
  assign resp_ready = owner_q ? lsu_resp_ready_i : ifu_resp_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      cnt_q       <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      cnt_q       <= cnt_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    cnt_d       = cnt_q;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_ifu) begin
          addr_d  = ifu_addr_i;
          we_d    = 1'b0;
          wdata_d = '0;
          wmask_d = '1;
          owner_d = 1'b0;
          last_d  = 1'b0;
          state_d = ISSUE;
        end else if (grant_lsu) begin
          addr_d  = lsu_addr_i;
          we_d    = lsu_we_i;
          wdata_d = lsu_wdata_i;
          wmask_d = lsu_wmask_i;
          owner_d = 1'b1;
          last_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 4'(MEM_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // A write acknowledges with zero instead of whatever pmem drives.
          if (owner_q) lsu_rdata_d = we_q ? '0 : mem_rdata_i;
          else         ifu_rdata_d = we_q ? '0 : mem_rdata_i;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ifu_req_ready_o  = !rst && (state_q == IDLE) && grant_ifu;
    lsu_req_ready_o  = !rst && (state_q == IDLE) && !grant_ifu && grant_lsu;
    ifu_resp_valid_o = !rst && (state_q == RESP) && !owner_q;
    lsu_resp_valid_o = !rst && (state_q == RESP) && owner_q;
    mem_en_o         = !rst && (state_q == ISSUE);
    mem_we_o         = mem_en_o && we_q;
    mem_addr_o       = mem_en_o ? addr_q  : '0;
    mem_wdata_o      = mem_en_o ? wdata_q : '0;
    mem_wmask_o      = mem_en_o ? wmask_q : '0;
    ifu_rdata_o      = ifu_rdata_q;
    lsu_rdata_o      = lsu_rdata_q;
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: cycle table on a MEM_LATENCY=1 instance, hand sequences on a MEM_LATENCY=4 instance.
module tb_pmem_arbiter;

  localparam logic [31:0] A0   = 32'h8000_0000;
  localparam logic [31:0] A4   = 32'h8000_0004;
  localparam logic [31:0] A8   = 32'h8000_0008;
  localparam logic [31:0] LA   = 32'h8000_0200;
  localparam logic [31:0] WA   = 32'h8000_0100;
  localparam logic [31:0] WD   = 32'hDEAD_BEEF;
  localparam logic [31:0] R413 = 32'h0000_0413;
  localparam logic [31:0] RL   = 32'h9234_5478;
  localparam logic [31:0] R4   = 32'h9234_567C;
  localparam logic [31:0] R8   = 32'h9234_5670;
  localparam logic [31:0] JUNK = 32'hBAD0_0BAD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // pmem contents: fixed pattern, with the reset-vector instruction at 0x80000000
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == A0) ? R413 : (a ^ 32'h1234_5678);
  endfunction

  // ---------------- MEM_LATENCY = 1 instance ----------------
  logic        rst, iv, irr, lv, lwe, lrr;
  logic [31:0] ia, la, lwd;
  logic [3:0]  lwm;
  logic        ifu_rdy, lsu_rdy, ifu_rv, lsu_rv, men, mwe;
  logic [31:0] maddr, mwdata, ifu_rd, lsu_rd, mrdata;
  logic [3:0]  mwmask;
  logic [31:0] pipe1;

  pmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .ifu_req_valid_i(iv), .ifu_req_ready_o(ifu_rdy), .ifu_addr_i(ia),
    .ifu_resp_valid_o(ifu_rv), .ifu_resp_ready_i(irr), .ifu_rdata_o(ifu_rd),
    .lsu_req_valid_i(lv), .lsu_req_ready_o(lsu_rdy), .lsu_addr_i(la),
    .lsu_we_i(lwe), .lsu_wdata_i(lwd), .lsu_wmask_i(lwm),
    .lsu_resp_valid_o(lsu_rv), .lsu_resp_ready_i(lrr), .lsu_rdata_o(lsu_rd),
    .mem_en_o(men), .mem_we_o(mwe), .mem_addr_o(maddr), .mem_wdata_o(mwdata),
    .mem_wmask_o(mwmask), .mem_rdata_i(mrdata)
  );

  // Read data is valid exactly MEM_LATENCY cycles after the strobe, junk otherwise.
  always @(posedge clk) pipe1 <= men ? memf(maddr) : JUNK;
  assign mrdata = pipe1;

  // ---------------- MEM_LATENCY = 4 instance ----------------
  logic        rst4, iv4, irr4, lv4, lwe4, lrr4;
  logic [31:0] ia4, la4, lwd4;
  logic [3:0]  lwm4;
  logic        ifu_rdy4, lsu_rdy4, ifu_rv4, lsu_rv4, men4, mwe4;
  logic [31:0] maddr4, mwdata4, ifu_rd4, lsu_rd4, mrdata4;
  logic [3:0]  mwmask4;
  logic [31:0] pipe4 [4];

  pmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst4),
    .ifu_req_valid_i(iv4), .ifu_req_ready_o(ifu_rdy4), .ifu_addr_i(ia4),
    .ifu_resp_valid_o(ifu_rv4), .ifu_resp_ready_i(irr4), .ifu_rdata_o(ifu_rd4),
    .lsu_req_valid_i(lv4), .lsu_req_ready_o(lsu_rdy4), .lsu_addr_i(la4),
    .lsu_we_i(lwe4), .lsu_wdata_i(lwd4), .lsu_wmask_i(lwm4),
    .lsu_resp_valid_o(lsu_rv4), .lsu_resp_ready_i(lrr4), .lsu_rdata_o(lsu_rd4),
    .mem_en_o(men4), .mem_we_o(mwe4), .mem_addr_o(maddr4), .mem_wdata_o(mwdata4),
    .mem_wmask_o(mwmask4), .mem_rdata_i(mrdata4)
  );

  always @(posedge clk) begin
    pipe4[0] <= men4 ? memf(maddr4) : JUNK;
    for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
  end
  assign mrdata4 = pipe4[3];

  // ---------------- cycle table ----------------
  typedef struct {
    logic        rst, iv;
    logic [31:0] ia;
    logic        irr, lv, lwe;
    logic [31:0] la, lwd;
    logic [3:0]  lwm;
    logic        lrr;
    logic [5:0]  ef;      // {ifu_ready, lsu_ready, ifu_resp_valid, lsu_resp_valid, mem_en, mem_we}
    logic [31:0] eaddr, ewd;
    logic [3:0]  ewm;
    logic [31:0] eir, elr;
  } vec_t;

  localparam int NV = 30;
  vec_t v [NV];

  function automatic vec_t mk(input logic r, input logic i_v, input logic [31:0] i_a, input logic i_rr,
                              input logic l_v, input logic l_we, input logic [31:0] l_a, input logic [31:0] l_wd,
                              input logic [3:0] l_wm, input logic l_rr, input logic [5:0] e_f,
                              input logic [31:0] e_a, input logic [31:0] e_wd, input logic [3:0] e_wm,
                              input logic [31:0] e_ir, input logic [31:0] e_lr);
    vec_t t;
    t.rst = r; t.iv = i_v; t.ia = i_a; t.irr = i_rr; t.lv = l_v; t.lwe = l_we; t.la = l_a;
    t.lwd = l_wd; t.lwm = l_wm; t.lrr = l_rr; t.ef = e_f; t.eaddr = e_a; t.ewd = e_wd;
    t.ewm = e_wm; t.eir = e_ir; t.elr = e_lr;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  logic [5:0] af;
  int n;
  logic seen;

  initial begin
    // reset hold with both requesters asserting
    for (int i = 0; i < 3; i++) v[i] = mk(1,1,A0,1, 1,0,LA,0,4'hF,1, 6'b000000, 0,0,0, 0,0);
    // IFU wins the first tie, then LSU read, then IFU again (round robin)
    v[3]  = mk(0,1,A0,1, 1,0,LA,0,4'hF,1, 6'b100000, 0,0,0,       0,    0);
    v[4]  = mk(0,1,A4,1, 1,0,LA,0,4'hF,1, 6'b000010, A0,0,4'hF,   0,    0);
    v[5]  = mk(0,1,A4,1, 1,0,LA,0,4'hF,1, 6'b000000, 0,0,0,       0,    0);
    v[6]  = mk(0,1,A4,1, 1,0,LA,0,4'hF,1, 6'b001000, 0,0,0,       R413, 0);
    v[7]  = mk(0,1,A4,1, 1,0,LA,0,4'hF,1, 6'b010000, 0,0,0,       R413, 0);
    v[8]  = mk(0,1,A4,1, 1,1,WA,WD,4'h3,1, 6'b000010, LA,0,4'hF,  R413, 0);
    v[9]  = mk(0,1,A4,1, 1,1,WA,WD,4'h3,1, 6'b000000, 0,0,0,      R413, 0);
    v[10] = mk(0,1,A4,1, 1,1,WA,WD,4'h3,1, 6'b000100, 0,0,0,      R413, RL);
    v[11] = mk(0,1,A4,1, 1,1,WA,WD,4'h3,1, 6'b100000, 0,0,0,      R413, RL);
    v[12] = mk(0,1,A8,1, 1,1,WA,WD,4'h3,1, 6'b000010, A4,0,4'hF,  R413, RL);
    v[13] = mk(0,1,A8,1, 1,1,WA,WD,4'h3,1, 6'b000000, 0,0,0,      R413, RL);
    v[14] = mk(0,1,A8,1, 1,1,WA,WD,4'h3,1, 6'b001000, 0,0,0,      R4,   RL);
    // LSU write, then held response with an IFU request pending
    v[15] = mk(0,1,A8,1, 1,1,WA,WD,4'h3,1, 6'b010000, 0,0,0,      R4,   RL);
    v[16] = mk(0,1,A8,1, 0,0,LA,0,4'hF,0,  6'b000011, WA,WD,4'h3, R4,   RL);
    v[17] = mk(0,1,A8,1, 0,0,LA,0,4'hF,0,  6'b000000, 0,0,0,      R4,   RL);
    for (int i = 18; i < 23; i++) v[i] = mk(0,1,A8,1, 0,0,LA,0,4'hF,0, 6'b000100, 0,0,0, R4, 0);
    v[23] = mk(0,1,A8,1, 0,0,LA,0,4'hF,1,  6'b000100, 0,0,0,      R4,   0);
    v[24] = mk(0,1,A8,1, 0,0,LA,0,4'hF,1,  6'b100000, 0,0,0,      R4,   0);
    // IFU response held one extra cycle
    v[25] = mk(0,0,A8,0, 0,0,LA,0,4'hF,1,  6'b000010, A8,0,4'hF,  R4,   0);
    v[26] = mk(0,0,A8,0, 0,0,LA,0,4'hF,1,  6'b000000, 0,0,0,      R4,   0);
    v[27] = mk(0,0,A8,0, 0,0,LA,0,4'hF,1,  6'b001000, 0,0,0,      R8,   0);
    v[28] = mk(0,0,A8,1, 0,0,LA,0,4'hF,1,  6'b001000, 0,0,0,      R8,   0);
    v[29] = mk(0,0,A8,1, 0,0,LA,0,4'hF,1,  6'b000000, 0,0,0,      R8,   0);

    rst = 1; iv = 0; ia = 0; irr = 0; lv = 0; lwe = 0; la = 0; lwd = 0; lwm = 0; lrr = 0;
    rst4 = 1; iv4 = 0; ia4 = 0; irr4 = 1; lv4 = 0; lwe4 = 0; la4 = 0; lwd4 = 0; lwm4 = 0; lrr4 = 1;
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < NV; k++) begin
      rst = v[k].rst; iv = v[k].iv; ia = v[k].ia; irr = v[k].irr; lv = v[k].lv;
      lwe = v[k].lwe; la = v[k].la; lwd = v[k].lwd; lwm = v[k].lwm; lrr = v[k].lrr;
      #1;
      af = {ifu_rdy, lsu_rdy, ifu_rv, lsu_rv, men, mwe};
      tests++;
      if (af !== v[k].ef || maddr !== v[k].eaddr || mwdata !== v[k].ewd || mwmask !== v[k].ewm ||
          ifu_rd !== v[k].eir || lsu_rd !== v[k].elr) begin
        fails++;
        $display("FAIL vec%0d: got flags=%b addr=%h wd=%h wm=%h ir=%h lr=%h want flags=%b addr=%h wd=%h wm=%h ir=%h lr=%h",
                 k, af, maddr, mwdata, mwmask, ifu_rd, lsu_rd,
                 v[k].ef, v[k].eaddr, v[k].ewd, v[k].ewm, v[k].eir, v[k].elr);
      end
      $display("[TB] vec%0d flags=%b addr=%h ir=%h lr=%h", k, af, maddr, ifu_rd, lsu_rd);
      @(posedge clk);
      #1;
    end

    // ---------------- MEM_LATENCY = 4 sequences ----------------
    rst4 = 0;
    @(posedge clk);
    #1;
    iv4 = 1; ia4 = A0;
    #1;
    chk("l4_ready", {31'd0, ifu_rdy4}, 1);
    @(posedge clk);
    #1;
    iv4 = 0;
    chk("l4_issue_en", {31'd0, men4}, 1);
    chk("l4_issue_addr", maddr4, A0);
    n = 1;
    while (!ifu_rv4 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("l4_resp_cycle", n, 6);
    chk("l4_rdata", ifu_rd4, R413);
    $display("[TB] l4 read A0 resp at T+%0d data=%h", n, ifu_rd4);
    @(posedge clk);
    #1;
    chk("l4_resp_one_cycle", {31'd0, ifu_rv4}, 0);

    // reset pulse while the access is in WAIT
    iv4 = 1; ia4 = 32'h8000_0010;
    @(posedge clk);
    #1;
    iv4 = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst4 = 1;
    #1;
    chk("l4_rst_outputs", {30'd0, ifu_rv4, men4}, 0);
    @(posedge clk);
    #1;
    rst4 = 0;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (ifu_rv4 || lsu_rv4 || men4) seen = 1;
    end
    chk("l4_abort_noresp", {31'd0, seen}, 0);
    $display("[TB] l4 aborted access, stray activity=%0d", seen);

    iv4 = 1; ia4 = 32'h8000_0014;
    #1;
    chk("l4_after_rst_ready", {31'd0, ifu_rdy4}, 1);
    @(posedge clk);
    #1;
    iv4 = 0;
    n = 1;
    while (!ifu_rv4 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("l4_after_rst_cycle", n, 6);
    chk("l4_after_rst_rdata", ifu_rd4, 32'h9234_566C);
    $display("[TB] l4 read 80000014 resp at T+%0d data=%h", n, ifu_rd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
